// File: rtl/minmax_tree.sv
// Pipelined N-lane min/max finder: per-beat extremum with winning lane index,
// plus a running extremum across packets delimited by in_last.
module minmax_tree #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned N_CH   = 4,
  parameter int unsigned SIGNED = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [N_CH*WIDTH-1:0]     in_data,
  input  logic                      in_mode,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [$clog2(N_CH)-1:0]   out_idx,
  output logic [WIDTH-1:0]          out_acc,
  output logic                      out_last
);

  localparam int unsigned LAT = $clog2(N_CH);
  localparam int unsigned FIN = LAT - 1;
  // XOR-ing the sign bit maps two's-complement order onto unsigned order.
  localparam logic [WIDTH-1:0] FLIP = (SIGNED != 0) ? {1'b1, {(WIDTH-1){1'b0}}} : '0;

  // True when cand strictly beats cur; ties keep cur, the lower lane.
  function automatic logic beats(input logic [WIDTH-1:0] cur,
                                 input logic [WIDTH-1:0] cand,
                                 input logic             mode);
    logic [WIDTH-1:0] kc;
    logic [WIDTH-1:0] kn;
    kc = cur ^ FLIP;
    kn = cand ^ FLIP;
    return mode ? (kn > kc) : (kn < kc);
  endfunction

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Level 0 is the raw input beat; level k>=1 holds N_CH>>k registered winners.
  for (genvar k = 0; k < LAT; k++) begin : g_lvl
    localparam int unsigned CNT = N_CH >> k;
    logic [WIDTH-1:0] val [CNT];
    logic [LAT-1:0]   idx [CNT];
    logic             vld;
    logic             mode;
    logic             last;

    if (k == 0) begin : g_in
      for (genvar j = 0; j < CNT; j++) begin : g_lane
        assign val[j] = in_data[j*WIDTH +: WIDTH];
        assign idx[j] = LAT'(j);
      end
      assign vld  = in_valid;
      assign mode = in_mode;
      assign last = in_last;
    end else begin : g_st
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld  <= 1'b0;
          mode <= 1'b0;
          last <= 1'b0;
          for (int j = 0; j < CNT; j++) begin
            val[j] <= '0;
            idx[j] <= '0;
          end
        end else if (adv) begin
          vld  <= g_lvl[k-1].vld;
          mode <= g_lvl[k-1].mode;
          last <= g_lvl[k-1].last;
          for (int j = 0; j < CNT; j++) begin
            if (beats(g_lvl[k-1].val[2*j], g_lvl[k-1].val[2*j+1], g_lvl[k-1].mode)) begin
              val[j] <= g_lvl[k-1].val[2*j+1];
              idx[j] <= g_lvl[k-1].idx[2*j+1];
            end else begin
              val[j] <= g_lvl[k-1].val[2*j];
              idx[j] <= g_lvl[k-1].idx[2*j];
            end
          end
        end
      end
    end
  end

  logic             acc_empty;
  logic             fin_sel_c;
  logic [WIDTH-1:0] fin_val_c;
  logic [LAT-1:0]   fin_idx_c;
  logic             acc_fresh_c;
  logic [WIDTH-1:0] acc_nxt_c;

  // Final pair compare and accumulator update feeding the output register.
  always_comb begin
    fin_sel_c   = beats(g_lvl[FIN].val[0], g_lvl[FIN].val[1], g_lvl[FIN].mode);
    fin_val_c   = fin_sel_c ? g_lvl[FIN].val[1] : g_lvl[FIN].val[0];
    fin_idx_c   = fin_sel_c ? g_lvl[FIN].idx[1] : g_lvl[FIN].idx[0];
    // A packet-closing beat leaving this cycle empties the accumulator for the new one.
    acc_fresh_c = acc_empty || (out_valid && out_ready && out_last);
    acc_nxt_c   = out_acc;
    if (acc_fresh_c || beats(out_acc, fin_val_c, g_lvl[FIN].mode)) begin
      acc_nxt_c = fin_val_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      out_acc   <= '0;
      out_last  <= 1'b0;
      acc_empty <= 1'b1;
    end else begin
      if (adv) begin
        out_valid <= g_lvl[FIN].vld;
        if (g_lvl[FIN].vld) begin
          out_data <= fin_val_c;
          out_idx  <= fin_idx_c;
          out_acc  <= acc_nxt_c;
          out_last <= g_lvl[FIN].last;
        end
      end
      if (adv && g_lvl[FIN].vld) begin
        acc_empty <= 1'b0;
      end else if (out_valid && out_ready && out_last) begin
        acc_empty <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_minmax_tree.sv
// Scoreboarded bench for minmax_tree: unsigned and signed instances share the
// stimulus; a lane-scan reference model predicts every result.
module tb_minmax_tree;

  localparam int W = 8;
  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic [N*W-1:0] in_data;
  logic          in_mode;
  logic          in_last;
  logic          out_ready;

  logic          in_ready_u, out_valid_u, out_last_u;
  logic [W-1:0]  out_data_u, out_acc_u;
  logic [1:0]    out_idx_u;
  logic          in_ready_s, out_valid_s, out_last_s;
  logic [W-1:0]  out_data_s, out_acc_s;
  logic [1:0]    out_idx_s;

  always #5 clk = ~clk;

  minmax_tree #(.WIDTH(W), .N_CH(N), .SIGNED(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_u),
    .in_data(in_data), .in_mode(in_mode), .in_last(in_last),
    .out_valid(out_valid_u), .out_ready(out_ready), .out_data(out_data_u),
    .out_idx(out_idx_u), .out_acc(out_acc_u), .out_last(out_last_u));

  minmax_tree #(.WIDTH(W), .N_CH(N), .SIGNED(1)) s_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_data(in_data), .in_mode(in_mode), .in_last(in_last),
    .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s),
    .out_idx(out_idx_s), .out_acc(out_acc_s), .out_last(out_last_s));

  typedef struct {
    logic [7:0] d_u; logic [1:0] i_u; logic [7:0] a_u;
    logic [7:0] d_s; logic [1:0] i_s; logic [7:0] a_s;
    logic       last;
  } exp_t;

  exp_t       q[$];
  logic [7:0] acc_log[$];
  int         errors = 0;
  int         checks = 0;
  int         pops = 0;
  int         nready_seen = 0;
  logic [7:0] m_acc_u, m_acc_s;
  bit         m_empty = 1'b1;
  bit         rnd_on;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int key(input logic [7:0] a, input bit sgn);
    if (sgn) return int'($signed(a));
    return int'(a);
  endfunction

  // Scan lanes upward, replacing the best only on a strict improvement.
  function automatic void ref_beat(input logic [31:0] d, input logic m, input bit sgn,
                                   output logic [7:0] v, output logic [1:0] ix);
    logic [7:0] x;
    int bk;
    v = d[7:0]; ix = 2'd0; bk = key(v, sgn);
    for (int i = 1; i < 4; i++) begin
      x = d[i*8 +: 8];
      if ((m && key(x, sgn) > bk) || (!m && key(x, sgn) < bk)) begin
        v = x; ix = 2'(i); bk = key(x, sgn);
      end
    end
  endfunction

  function automatic logic [7:0] acc_comb(input logic [7:0] a, input logic [7:0] v,
                                          input logic m, input bit sgn);
    if (m) return (key(v, sgn) > key(a, sgn)) ? v : a;
    return (key(v, sgn) < key(a, sgn)) ? v : a;
  endfunction

  task automatic push_expected(input logic [31:0] d, input logic m, input logic l);
    exp_t e;
    ref_beat(d, m, 1'b0, e.d_u, e.i_u);
    ref_beat(d, m, 1'b1, e.d_s, e.i_s);
    m_acc_u = m_empty ? e.d_u : acc_comb(m_acc_u, e.d_u, m, 1'b0);
    m_acc_s = m_empty ? e.d_s : acc_comb(m_acc_s, e.d_s, m, 1'b1);
    m_empty = l;
    e.a_u = m_acc_u; e.a_s = m_acc_s; e.last = l;
    q.push_back(e);
  endtask

  // Called at posedge+1; returns at posedge+1 just after the beat is accepted.
  task automatic send(input logic [31:0] d, input logic m, input logic l);
    int n = 0;
    in_data = d; in_mode = m; in_last = l; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready_u && n < 50) begin n++; @(negedge clk); end
    if (!in_ready_u) begin
      check("accept_timeout", 32'(in_ready_u), 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    push_expected(d, m, l);
    #1 in_valid = 1'b0;
  endtask

  function automatic logic [7:0] rnd_lane();
    logic [7:0] pick [4];
    pick[0] = 8'h00; pick[1] = 8'h7F; pick[2] = 8'h80; pick[3] = 8'hFF;
    if ($urandom_range(0, 2) == 0) return pick[$urandom_range(0, 3)];
    return 8'($urandom_range(0, 255));
  endfunction

  // Monitor: handshake and hold checks against the scoreboard queue.
  logic       stalled = 1'b0;
  logic [7:0] h_d, h_a;
  logic [1:0] h_i;
  logic       h_l;
  always @(negedge clk) begin
    if (!rst_n) begin
      stalled = 1'b0;
    end else begin
      check("in_ready", 32'(in_ready_u), 32'(!out_valid_u || out_ready));
      check("valid_match", 32'(out_valid_s), 32'(out_valid_u));
      if (!in_ready_u) nready_seen++;
      if (stalled && out_valid_u) begin
        check("hold_data", 32'(out_data_u), 32'(h_d));
        check("hold_idx", 32'(out_idx_u), 32'(h_i));
        check("hold_acc", 32'(out_acc_u), 32'(h_a));
        check("hold_last", 32'(out_last_u), 32'(h_l));
      end
      if (out_valid_u && out_ready) begin
        if (q.size() == 0) begin
          check("unexpected_out", 32'(out_valid_u), 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          pops++;
          acc_log.push_back(out_acc_u);
          check("data_u", 32'(out_data_u), 32'(e.d_u));
          check("idx_u", 32'(out_idx_u), 32'(e.i_u));
          check("acc_u", 32'(out_acc_u), 32'(e.a_u));
          check("last_u", 32'(out_last_u), 32'(e.last));
          check("data_s", 32'(out_data_s), 32'(e.d_s));
          check("idx_s", 32'(out_idx_s), 32'(e.i_s));
          check("acc_s", 32'(out_acc_s), 32'(e.a_s));
          check("last_s", 32'(out_last_s), 32'(e.last));
        end
      end
      stalled = out_valid_u && !out_ready;
      h_d = out_data_u; h_i = out_idx_u; h_a = out_acc_u; h_l = out_last_u;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, n;
    logic [31:0] d;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_mode = 1'b0; in_last = 1'b0;
    out_ready = 1'b1; rnd_on = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    @(negedge clk);
    check("rst_valid", 32'(out_valid_u), 32'd0);
    check("rst_data", 32'(out_data_u), 32'd0);
    check("rst_idx", 32'(out_idx_u), 32'd0);
    check("rst_acc", 32'(out_acc_u), 32'd0);
    check("rst_last", 32'(out_last_u), 32'd0);
    check("rst_in_ready", 32'(in_ready_u), 32'd1);

    // Unsigned min, two-cycle latency
    @(posedge clk); #1;
    send(32'h4005F022, 1'b0, 1'b1);
    @(negedge clk); check("lat_early", 32'(out_valid_u), 32'd0);
    @(negedge clk); check("lat_valid", 32'(out_valid_u), 32'd1);
    check("t1_data", 32'(out_data_u), 32'h05);
    check("t1_idx", 32'(out_idx_u), 32'd2);

    // Max with tie: lower lane wins
    @(posedge clk); #1;
    send(32'h90109001, 1'b1, 1'b1);
    @(negedge clk); @(negedge clk);
    check("t2_data", 32'(out_data_u), 32'h90);
    check("t2_idx", 32'(out_idx_u), 32'd1);

    // Signed min: 8'h80 is the smallest
    @(posedge clk); #1;
    send(32'h7F80FF00, 1'b0, 1'b1);
    @(negedge clk); @(negedge clk);
    check("t3_data_s", 32'(out_data_s), 32'h80);
    check("t3_idx_s", 32'(out_idx_s), 32'd2);

    // Packet accumulation
    @(posedge clk); #1;
    acc_log.delete();
    send(32'h30556070, 1'b0, 1'b0);
    send(32'h80122099, 1'b0, 1'b0);
    send(32'h44F09050, 1'b0, 1'b1);
    send(32'h50607080, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    check("t4_count", 32'(acc_log.size()), 32'd4);
    if (acc_log.size() == 4) begin
      check("t4_acc0", 32'(acc_log[0]), 32'h30);
      check("t4_acc1", 32'(acc_log[1]), 32'h12);
      check("t4_acc2", 32'(acc_log[2]), 32'h12);
      check("t4_acc3", 32'(acc_log[3]), 32'h50);
    end

    // Backpressure mid-stream
    @(posedge clk); #1;
    nready_seen = 0; p0 = pops;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          d = {rnd_lane(), rnd_lane(), rnd_lane(), rnd_lane()};
          send(d, 1'($urandom_range(0, 1)), 1'(i == 5));
        end
      end
      begin
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    repeat (5) @(negedge clk);
    check("t5_in_ready_drop", 32'(nready_seen > 0), 32'd1);
    check("t5_count", 32'(pops - p0), 32'd6);

    // Reset with beats in flight
    @(posedge clk); #1;
    send(32'h01020304, 1'b1, 1'b0);
    send(32'h05060708, 1'b1, 1'b0);
    rst_n = 1'b0;
    q.delete(); m_empty = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("t6_rst_valid", 32'(out_valid_u), 32'd0);
    check("t6_rst_acc", 32'(out_acc_u), 32'd0);
    @(posedge clk); #1;
    p0 = pops; acc_log.delete();
    send(32'h11223344, 1'b0, 1'b1);
    repeat (6) @(negedge clk);
    check("t6_one_out", 32'(pops - p0), 32'd1);
    if (acc_log.size() == 1) check("t6_acc", 32'(acc_log[0]), 32'h11);

    // Randomized stream with random backpressure and gaps
    @(posedge clk); #1;
    rnd_on = 1'b1;
    fork
      begin
        while (rnd_on) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 3) != 0);
        end
      end
      begin
        for (int i = 0; i < 300; i++) begin
          d = {rnd_lane(), rnd_lane(), rnd_lane(), rnd_lane()};
          send(d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
          repeat ($urandom_range(0, 2)) @(posedge clk);
          if (in_valid == 1'b0) #0;
        end
        rnd_on = 1'b0;
      end
    join
    out_ready = 1'b1;
    n = 0;
    while (q.size() != 0 && n < 100) begin n++; @(negedge clk); end
    check("drain_empty", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
